// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin / fixed-select arbitration mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b1;
    localparam logic MODE_RR    = 1'b0;

    // Index width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_rr_pick.sv
// Rotating priority encoder: the first requester after ptr (wrapping) wins.
module rr_pick #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_CH]) begin
                gnt_idx = SEL_W'((int'(ptr) + k) % N_CH);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel selector with valid/ready handshakes, fixed or round-robin grant,
// registered output stage, bad-select flag and a saturating transfer counter.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  sel_en,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_sel,
    output logic [CNT_W-1:0]      xfer_cnt
);

    // Channel tables padded to a power of two so any sel value indexes safely.
    localparam int N_PAD = 1 << SEL_W;

    logic [WIDTH-1:0] w_ch_data [N_PAD];
    logic [N_PAD-1:0] w_valid_pad;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_err_sel;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic [SEL_W-1:0] r_ptr;

    logic             w_rr_mode;
    logic             w_load_ok;
    logic             w_sel_in_range;
    logic             w_fix_vld;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic             w_xfer_in;
    logic             w_bad_sel;

    for (genvar gi = 0; gi < N_PAD; gi++) begin : g_pad
        if (gi < N_CH) begin : g_live
            assign w_ch_data[gi]   = in_data[gi*WIDTH +: WIDTH];
            assign w_valid_pad[gi] = in_valid[gi];
        end else begin : g_dead
            assign w_ch_data[gi]   = '0;
            assign w_valid_pad[gi] = 1'b0;
        end
    end

    rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_vld (w_rr_vld)
    );

    assign w_rr_mode      = (sel_en == MODE_RR);
    assign w_load_ok      = !r_out_valid || out_ready;
    assign w_sel_in_range = (int'(sel) < N_CH);
    assign w_fix_vld      = w_sel_in_range && w_valid_pad[sel];

    assign w_gnt_idx = w_rr_mode ? w_rr_idx : sel;
    assign w_gnt_vld = w_rr_mode ? w_rr_vld : w_fix_vld;
    assign w_xfer_in = w_gnt_vld && w_load_ok;
    assign w_bad_sel = (sel_en == MODE_FIXED) && (|in_valid) && !w_sel_in_range;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rdy
        assign in_ready[gi] = w_xfer_in && (w_gnt_idx == SEL_W'(gi));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_err_sel   <= 1'b0;
            r_xfer_cnt  <= '0;
            r_ptr       <= SEL_W'(N_CH - 1);
        end else begin
            r_err_sel <= w_bad_sel;
            if (r_out_valid && out_ready && (r_xfer_cnt != '1)) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
            // A load on the same edge as a drain keeps out_valid high.
            if (w_xfer_in) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ch_data[w_gnt_idx];
                r_out_ch    <= w_gnt_idx;
                if (w_rr_mode) begin
                    r_ptr <= w_gnt_idx;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign err_sel   = r_err_sel;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: a 4-channel instance with a 4-bit counter and a 3-channel instance.
module tb_rr_arb_mux;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic        a_sel_en;
    logic [1:0]  a_sel;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_ch;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_err_sel;
    logic [3:0]  a_xfer_cnt;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_sel_en;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_err_sel;
    logic [15:0] b_xfer_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    rr_arb_mux #(.WIDTH(8), .N_CH(4), .CNT_W(4)) u_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .sel_en    (a_sel_en),
        .sel       (a_sel),
        .out_data  (a_out_data),
        .out_ch    (a_out_ch),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .err_sel   (a_err_sel),
        .xfer_cnt  (a_xfer_cnt)
    );

    rr_arb_mux #(.WIDTH(8), .N_CH(3), .CNT_W(16)) u_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .sel_en    (b_sel_en),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_ch    (b_out_ch),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .err_sel   (b_err_sel),
        .xfer_cnt  (b_xfer_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && a_out_valid && a_out_ready)
            $display("A xfer ch=%0d data=%02h cnt=%0d", a_out_ch, a_out_data, a_xfer_cnt);
        if (reset_n && b_out_valid && b_out_ready)
            $display("B xfer ch=%0d data=%02h cnt=%0d", b_out_ch, b_out_data, b_xfer_cnt);
    end

    initial begin
        reset_n     = 1'b0;
        a_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        a_in_valid  = 4'b0000;
        a_sel_en    = 1'b0;
        a_sel       = 2'd0;
        a_out_ready = 1'b0;
        b_in_data   = {8'hB2, 8'hB1, 8'hB0};
        b_in_valid  = 3'b000;
        b_sel_en    = 1'b0;
        b_sel       = 2'd0;
        b_out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        chk("rst_out_ch",    32'(a_out_ch),    32'd0);
        chk("rst_err_sel",   32'(b_err_sel),   32'd0);
        chk("rst_xfer_cnt",  32'(a_xfer_cnt),  32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Round-robin fairness with all channels requesting
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_in_ready", 32'(a_in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_out_ch",    32'(a_out_ch),    32'(k % 4));
            chk("rr_out_data",  32'(a_out_data),  32'(8'hA0 + (k % 4)));
            chk("rr_out_valid", 32'(a_out_valid), 32'd1);
        end
        chk("rr_xfer_cnt", 32'(a_xfer_cnt), 32'd4);

        // Asynchronous reset mid-burst
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_xfer_cnt",  32'(a_xfer_cnt),  32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'b0001);
        tick();
        chk("post_rst_out_ch",    32'(a_out_ch),    32'd0);
        chk("post_rst_out_valid", 32'(a_out_valid), 32'd1);

        // Fixed mode leaves the RR pointer at channel 0
        a_in_valid = 4'b0110;
        a_sel_en   = 1'b1;
        a_sel      = 2'd2;
        #1;
        chk("fix_in_ready", 32'(a_in_ready), 32'b0100);
        tick();
        chk("fix_out_ch",   32'(a_out_ch),   32'd2);
        chk("fix_out_data", 32'(a_out_data), 32'hA2);
        a_sel_en   = 1'b0;
        a_in_valid = 4'b1010;
        #1;
        chk("fix_ptr_in_ready", 32'(a_in_ready), 32'b0010);
        tick();
        chk("fix_ptr_out_ch", 32'(a_out_ch), 32'd1);

        // Backpressure then same-edge drain and load
        a_out_ready = 1'b0;
        a_in_valid  = 4'b1111;
        #1;
        chk("bp_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        chk("bp_out_data",  32'(a_out_data),  32'hA1);
        chk("bp_out_ch",    32'(a_out_ch),    32'd1);
        chk("bp_out_valid", 32'(a_out_valid), 32'd1);
        a_in_data   = {8'hA3, 8'hA2, 8'h5C, 8'hA0};
        a_in_valid  = 4'b0010;
        a_out_ready = 1'b1;
        #1;
        chk("dl_in_ready", 32'(a_in_ready), 32'b0010);
        tick();
        chk("dl_out_data",  32'(a_out_data),  32'h5C);
        chk("dl_out_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 4'b0000;
        tick();
        chk("drain_out_valid", 32'(a_out_valid), 32'd0);
        chk("drain_out_data",  32'(a_out_data),  32'h5C);
        chk("drain_xfer_cnt",  32'(a_xfer_cnt),  32'd4);

        // Counter saturation at 15 with a 4-bit counter
        a_in_valid = 4'b1111;
        for (int k = 0; k < 11; k++) tick();
        chk("sat_cnt_14", 32'(a_xfer_cnt), 32'd14);
        for (int k = 0; k < 9; k++) tick();
        chk("sat_cnt_15", 32'(a_xfer_cnt), 32'd15);
        a_in_valid = 4'b0000;

        // Bad select on a 3-channel instance
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;
        tick();
        chk("b_load_out_ch",    32'(b_out_ch),    32'd0);
        chk("b_load_out_valid", 32'(b_out_valid), 32'd1);
        b_out_ready = 1'b0;
        b_sel_en    = 1'b1;
        b_sel       = 2'd3;
        #1;
        chk("bad_in_ready", 32'(b_in_ready), 32'd0);
        tick();
        chk("bad_err_sel",   32'(b_err_sel),   32'd1);
        chk("bad_out_valid", 32'(b_out_valid), 32'd1);
        chk("bad_out_data",  32'(b_out_data),  32'hB0);
        b_sel = 2'd1;
        tick();
        chk("bad_err_clear", 32'(b_err_sel), 32'd0);
        b_out_ready = 1'b1;
        #1;
        chk("b_fix_in_ready", 32'(b_in_ready), 32'b010);
        tick();
        chk("b_fix_out_ch",   32'(b_out_ch),   32'd1);
        chk("b_fix_out_data", 32'(b_out_data), 32'hB1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
